dot_accumulator: RTL
====================

// Module: dot_accumulator
// PURPOSE
//  Downstream of the ALU. Collects a stream of ALU products (alu_out of multiply ops) for one
//  matrix-element dot product, sums them and presents the finished element to the writeback
//  stage. One dot product runs at a time. Input and output use valid/ready handshakes.
// PARAMETERS
//  DATA_W   16   width of ALU product input and of the result; matches the ALU datapath
//  LEN_W    8    width of the dot-product length field; max length 2**LEN_W-1
// PORTS
//  clock      in   1        rising-edge clock
//  reset_n    in   1        asynchronous, active-low reset
//  start      in   1        begin a new dot product; accepted only in IDLE
//  len        in   LEN_W    number of products to sum; sampled with accepted start
//  in_valid   in   1        in_data holds a product
//  in_data    in   DATA_W   ALU product (two's complement)
//  in_ready   out  1        block accepts in_data this cycle
//  out_valid  out  1        result/ovf valid
//  out_ready  in   1        writeback consumes the result
//  result     out  DATA_W   accumulated sum
//  ovf        out  1        sticky signed overflow for this dot product
//  busy       out  1        high in ACCUM or DONE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; acc=0, count=0; in_ready=0, out_valid=0,
//   result=0, ovf=0, busy=0. Reset mid-operation abandons the dot product; nothing is emitted.
//  FSM: IDLE -> ACCUM on start&&len!=0 (acc<=0, ovf<=0, count<=len).
//   IDLE -> DONE on start&&len==0 (result=0, ovf=0); no input is consumed.
//   ACCUM -> DONE on the beat that accepts the last product (count==1).
//   DONE -> IDLE on out_valid&&out_ready.
//   start is ignored outside IDLE (no queueing).
//  Input handshake: in_ready=1 only in ACCUM (registered, so it asserts the cycle after start).
//   A beat is accepted when in_valid&&in_ready. One product per cycle max; in_data is ignored
//   when not accepted. in_valid may drop at any time; count/acc hold.
//  Arithmetic: acc <= acc + in_data, DATA_W bits, two's-complement wraparound (no saturation).
//   ovf is set when both operands have the same sign and the sum's sign differs; once set it
//   stays set until the next accepted start.
//  Output: out_valid=1 exactly in DONE. result and ovf are registered and stable while
//   out_valid=1 && !out_ready. The last product is included in result on the first DONE cycle.
//   Latency is 1 cycle from the last accepted beat to out_valid.
//  The earliest new start is accepted the cycle after the handshake that leaves DONE.
//  busy = (state != IDLE).
// TESTING
//  1. Reset: reset_n=0 mid-ACCUM -> all outputs 0 immediately; after release IDLE, in_ready=0.
//  2. start,len=3; products 6,30,12 back-to-back -> out_valid the cycle after 3rd beat,
//     result=48, ovf=0.
//  3. Same stream with in_valid gaps and out_ready held low 4 cycles -> result=48 held
//     stable; clears on handshake.
//  4. len=2; products 16'h7FFF,16'h0001 -> result=16'h8000, ovf=1. Next dot product
//     len=1, product 5 -> result=5, ovf=0.
//  5. len=0 -> out_valid next cycle, result=0, in_ready never asserted.
//  6. start pulsed during ACCUM and DONE -> ignored; count/result unaffected.

Source files
------------

// File: rtl/dot_accumulator.sv
// dot_accumulator
//   Sums a stream of ALU products into one dot-product element and hands the
//   result to writeback. One dot product runs at a time.
//
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      begin a new dot product (accepted only while idle)
//   len        number of products to sum, sampled with an accepted start
//   in_valid   in_data holds a product
//   in_data    ALU product (two's complement)
//   in_ready   block accepts in_data this cycle
//   out_valid  result/ovf valid
//   out_ready  writeback consumes the result
//   result     accumulated sum (wraps at DATA_W bits)
//   ovf        sticky signed overflow for the current dot product
//   busy       a dot product is in progress or waiting to be consumed
module dot_accumulator #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sum;
  logic [LEN_W-1:0]  count;
  logic              ovf_q;
  logic              accept;
  logic              add_ovf;

  assign accept  = (state == ACCUM) && in_valid;
  assign sum     = acc + in_data;
  // Signed overflow: operands agree in sign but the wrapped sum does not.
  assign add_ovf = (acc[DATA_W-1] == in_data[DATA_W-1]) &&
                   (sum[DATA_W-1] != acc[DATA_W-1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        if (accept && (count == LEN_W'(1))) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      ovf_q <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf_q <= 1'b0;
            count <= len;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= sum;
            ovf_q <= ovf_q | add_ovf;
            count <= count - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs come straight from flops, so the result stays stable while
  // the writeback stage stalls.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = acc;
  assign ovf       = ovf_q;

endmodule
